seeg_frame_packer: RTL

- Sits directly downstream of the sEEG acquisition core (`seeg`) and consumes its per-channel sample stream.
- Collects one complete sweep of `N_CH` channels into a word FIFO, then serialises it as a framed byte stream for the host link.
- Frame layout: header, frame counter, sample words, XOR checksum.
- Frames that are incomplete or malformed never reach the output.

---
 rtl/seeg_frame_packer.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/seeg_frame_packer.sv
// Packs N_CH-channel sEEG sweeps into byte frames: header, counter, [timestamp], samples, XOR sum.
// Optional timestamp field enabled by defining SEEG_PACK_TIMESTAMP_EN.
module seeg_frame_packer #(
  parameter int unsigned N_CH       = 32,
  parameter int unsigned FIFO_DEPTH = 128,
  parameter logic [15:0] HDR_WORD   = 16'hA55A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        record_active,
  input  logic        sample_valid,
  input  logic        sample_first,
  input  logic [7:0]  sample_chan,
  input  logic [15:0] sample_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic        seq_error
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  typedef logic [PW-1:0] ptr_t;

`ifdef SEEG_PACK_TIMESTAMP_EN
  typedef enum logic [3:0] {StIdle, StHdrH, StHdrL, StCntH, StCntL, StTs3, StTs2, StTs1, StTs0,
                            StDatH, StDatL, StCsum} state_e;
`else
  typedef enum logic [3:0] {StIdle, StHdrH, StHdrL, StCntH, StCntL, StDatH, StDatL,
                            StCsum} state_e;
`endif

  logic [15:0] mem [FIFO_DEPTH];
  ptr_t        wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  ptr_t        waddr, level_wr, level_rd, free_space;
  logic [8:0]  exp_q, exp_d;
  logic        open_q, open_d, we, ovf_d, seq_d, valid_d, hs;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;
  state_e      state_q, state_d;
  logic [7:0]  beat_q, beat_d, csum_q, csum_d;
  logic [15:0] fc_d, rd_word;

  // Space is judged against the last committed frame: an open sweep is always rewound first.
  assign level_wr   = commit_ptr_q - rd_ptr_q;
  assign free_space = ptr_t'(FIFO_DEPTH) - level_wr;
  assign drop_sum   = {1'b0, drop_count} + {15'd0, drop_inc};

`ifdef SEEG_PACK_TIMESTAMP_EN
  localparam int unsigned TSD = FIFO_DEPTH / N_CH;
  localparam int unsigned TW  = (TSD > 1) ? $clog2(TSD) : 1;
  logic [31:0]   ts_cnt_q, ts_cap_q, ts_out;
  logic [31:0]   ts_mem [TSD];
  logic [TW-1:0] ts_wptr_q, ts_rptr_q;
  logic          ts_cap, commit_ev, ts_adv;
  assign ts_out = ts_mem[ts_rptr_q];
`endif

  // Write side: speculative wr_ptr, commit_ptr only moves on a complete sweep.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    exp_d        = exp_q;
    open_d       = open_q;
    drop_inc     = 2'd0;
    ovf_d        = overflow;
    seq_d        = seq_error;
    we           = 1'b0;
    waddr        = wr_ptr_q;
`ifdef SEEG_PACK_TIMESTAMP_EN
    ts_cap       = 1'b0;
    commit_ev    = 1'b0;
`endif
    if (!record_active) begin
      if (open_q) begin
        wr_ptr_d = commit_ptr_q;
        open_d   = 1'b0;
        drop_inc = 2'd1;
      end
    end else if (sample_valid) begin
      if (sample_first) begin
        if (open_q) begin
          drop_inc = 2'd1;
          seq_d    = 1'b1;
        end
        if (free_space < ptr_t'(N_CH)) begin
          drop_inc = drop_inc + 2'd1;
          ovf_d    = 1'b1;
          open_d   = 1'b0;
          wr_ptr_d = commit_ptr_q;
        end else begin
          we       = 1'b1;
          waddr    = commit_ptr_q;
          wr_ptr_d = commit_ptr_q + 1'b1;
          exp_d    = 9'd1;
          open_d   = 1'b1;
`ifdef SEEG_PACK_TIMESTAMP_EN
          ts_cap   = 1'b1;
`endif
        end
      end else if (open_q) begin
        if ({1'b0, sample_chan} == exp_q) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          exp_d    = exp_q + 9'd1;
          if (exp_q == 9'(N_CH - 1)) begin
            commit_ptr_d = wr_ptr_q + 1'b1;
            open_d       = 1'b0;
`ifdef SEEG_PACK_TIMESTAMP_EN
            commit_ev    = 1'b1;
`endif
          end
        end else begin
          drop_inc = 2'd1;
          seq_d    = 1'b1;
          open_d   = 1'b0;
          wr_ptr_d = commit_ptr_q;
        end
      end
    end
  end

  assign rd_word  = mem[rd_ptr_q[AW-1:0]];
  assign level_rd = commit_ptr_q - rd_ptr_q;
  assign hs       = out_valid & out_ready;

  always_comb begin
    out_data = 8'h00;
    case (state_q)
      StHdrH:  out_data = HDR_WORD[15:8];
      StHdrL:  out_data = HDR_WORD[7:0];
      StCntH:  out_data = frame_count[15:8];
      StCntL:  out_data = frame_count[7:0];
`ifdef SEEG_PACK_TIMESTAMP_EN
      StTs3:   out_data = ts_out[31:24];
      StTs2:   out_data = ts_out[23:16];
      StTs1:   out_data = ts_out[15:8];
      StTs0:   out_data = ts_out[7:0];
`endif
      StDatH:  out_data = rd_word[15:8];
      StDatL:  out_data = rd_word[7:0];
      StCsum:  out_data = csum_q;
      default: out_data = 8'h00;
    endcase
  end

  // Read FSM; frame_count only changes in CSUM, so CNT_H/CNT_L see the value from HDR_H entry.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    csum_d   = csum_q;
    fc_d     = frame_count;
`ifdef SEEG_PACK_TIMESTAMP_EN
    ts_adv   = 1'b0;
`endif
    case (state_q)
      StIdle: if (level_rd >= ptr_t'(N_CH)) state_d = StHdrH;
      StHdrH: if (hs) state_d = StHdrL;
      StHdrL: if (hs) begin
        state_d = StCntH;
        csum_d  = 8'h00;
      end
      StCntH: if (hs) begin
        state_d = StCntL;
        csum_d  = csum_q ^ out_data;
      end
      StCntL: if (hs) begin
`ifdef SEEG_PACK_TIMESTAMP_EN
        state_d = StTs3;
`else
        state_d = StDatH;
`endif
        csum_d  = csum_q ^ out_data;
        beat_d  = 8'd0;
      end
`ifdef SEEG_PACK_TIMESTAMP_EN
      StTs3: if (hs) begin
        state_d = StTs2;
        csum_d  = csum_q ^ out_data;
      end
      StTs2: if (hs) begin
        state_d = StTs1;
        csum_d  = csum_q ^ out_data;
      end
      StTs1: if (hs) begin
        state_d = StTs0;
        csum_d  = csum_q ^ out_data;
      end
      StTs0: if (hs) begin
        state_d = StDatH;
        csum_d  = csum_q ^ out_data;
        ts_adv  = 1'b1;
      end
`endif
      StDatH: if (hs) begin
        state_d = StDatL;
        csum_d  = csum_q ^ out_data;
      end
      StDatL: if (hs) begin
        csum_d   = csum_q ^ out_data;
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (beat_q == 8'(N_CH - 1)) begin
          state_d = StCsum;
        end else begin
          state_d = StDatH;
          beat_d  = beat_q + 8'd1;
        end
      end
      StCsum: if (hs) begin
        fc_d    = frame_count + 16'd1;
        state_d = (level_rd >= ptr_t'(N_CH)) ? StHdrH : StIdle;
      end
      default: state_d = StIdle;
    endcase
    valid_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      exp_q        <= '0;
      open_q       <= 1'b0;
      state_q      <= StIdle;
      beat_q       <= '0;
      csum_q       <= '0;
      out_valid    <= 1'b0;
      frame_count  <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      exp_q        <= exp_d;
      open_q       <= open_d;
      state_q      <= state_d;
      beat_q       <= beat_d;
      csum_q       <= csum_d;
      out_valid    <= valid_d;
      frame_count  <= fc_d;
      drop_count   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overflow     <= ovf_d;
      seq_error    <= seq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW-1:0]] <= sample_data;
  end

`ifdef SEEG_PACK_TIMESTAMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q  <= '0;
      ts_cap_q  <= '0;
      ts_wptr_q <= '0;
      ts_rptr_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (ts_cap) ts_cap_q <= ts_cnt_q;
      if (commit_ev) ts_wptr_q <= (ts_wptr_q == TW'(TSD - 1)) ? '0 : ts_wptr_q + 1'b1;
      if (ts_adv) ts_rptr_q <= (ts_rptr_q == TW'(TSD - 1)) ? '0 : ts_rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (commit_ev) ts_mem[ts_wptr_q] <= ts_cap_q;
  end
`endif

endmodule
